// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the data memory load/store port
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int HOST_PRIO = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [2:0]        c_funct3,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic [2:0]        h_funct3,
    output logic              h_gnt,
    output logic              h_done,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_RD
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              grant;
    logic              pick_host;
    logic              sel_we;
    logic [2:0]        sel_f3;
    logic              own_host;
    logic              last_host;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        f3_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] h_rdata_q;

    // Stores accept only byte/half/word; loads add the two unsigned forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Host wins if it is alone, if it has fixed priority, or if the core won last time.
    assign pick_host = h_req & (~c_req | (HOST_PRIO != 0) | ~last_host);
    assign sel_we    = pick_host ? h_we     : c_we;
    assign sel_f3    = pick_host ? h_funct3 : c_funct3;

    assign mem_A      = addr_q;
    assign mem_WD     = wdata_q;
    assign mem_funct3 = f3_q;
    assign c_rdata    = c_rdata_q;
    assign h_rdata    = h_rdata_q;
    assign c_err      = c_done & err_q;
    assign h_err      = h_done & err_q;

    // Next state, grants, done pulses and write enable; reset forces all strobes low.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        c_gnt    = 1'b0;
        h_gnt    = 1'b0;
        c_done   = 1'b0;
        h_done   = 1'b0;
        mem_WE   = 1'b0;
        case (state)
            S_IDLE: begin
                if (c_req | h_req) begin
                    grant    = 1'b1;
                    c_gnt    = ~pick_host;
                    h_gnt    = pick_host;
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_WE   = we_q & ~err_q;
                state_nx = S_RESP;
            end
            S_RESP: begin
                c_done   = ~own_host;
                h_done   = own_host;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (RST) begin
            grant    = 1'b0;
            c_gnt    = 1'b0;
            h_gnt    = 1'b0;
            c_done   = 1'b0;
            h_done   = 1'b0;
            mem_WE   = 1'b0;
            state_nx = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Capture the winning request and remember who won for the next tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            own_host  <= 1'b0;
            last_host <= 1'b1;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= 3'b000;
        end else if (grant) begin
            own_host  <= pick_host;
            last_host <= pick_host;
            we_q      <= sel_we;
            err_q     <= ~f3_legal(sel_we, sel_f3);
            addr_q    <= pick_host ? h_addr  : c_addr;
            wdata_q   <= pick_host ? h_wdata : c_wdata;
            f3_q      <= sel_f3;
        end
    end

    // Load data is taken from the memory at the end of the access cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else if (state == S_ACCESS && !we_q && !err_q) begin
            if (own_host) h_rdata_q <= mem_RD;
            else          c_rdata_q <= mem_RD;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        c_req, c_we, h_req, h_we;
    logic [31:0] c_addr, c_wdata, h_addr, h_wdata;
    logic [2:0]  c_funct3, h_funct3;
    logic        c_gnt, c_done, c_err, h_gnt, h_done, h_err;
    logic [31:0] c_rdata, h_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;
    logic [2:0]  mem_funct3;

    logic        p_c_req, p_h_req;
    logic        p_c_gnt, p_c_done, p_c_err, p_h_gnt, p_h_done, p_h_err;
    logic [31:0] p_c_rdata, p_h_rdata, p_mem_A, p_mem_WD;
    logic [31:0] p_mem_RD = 32'h0;
    logic        p_mem_WE;
    logic [2:0]  p_mem_funct3;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;

    logic [7:0] mem [0:255];

    always #5 CLK = ~CLK;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .HOST_PRIO(0)) dut (
        .CLK(CLK), .RST(RST),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata), .c_err(c_err),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_funct3(h_funct3),
        .h_gnt(h_gnt), .h_done(h_done), .h_rdata(h_rdata), .h_err(h_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_funct3(mem_funct3), .mem_RD(mem_RD)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .HOST_PRIO(1)) dut_prio (
        .CLK(CLK), .RST(RST),
        .c_req(p_c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
        .c_gnt(p_c_gnt), .c_done(p_c_done), .c_rdata(p_c_rdata), .c_err(p_c_err),
        .h_req(p_h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_funct3(h_funct3),
        .h_gnt(p_h_gnt), .h_done(p_h_done), .h_rdata(p_h_rdata), .h_err(p_h_err),
        .mem_A(p_mem_A), .mem_WD(p_mem_WD), .mem_WE(p_mem_WE), .mem_funct3(p_mem_funct3),
        .mem_RD(p_mem_RD)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-addressed memory model: combinational read with size/sign handling, write on clock.
    logic [7:0] a0, a1, a2, a3;
    always_comb begin
        a0 = mem_A[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        case (mem_funct3)
            3'b000:  mem_RD = {{24{mem[a0][7]}}, mem[a0]};
            3'b001:  mem_RD = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b100:  mem_RD = {24'h0, mem[a0]};
            3'b101:  mem_RD = {16'h0, mem[a1], mem[a0]};
            default: mem_RD = {mem[a3], mem[a2], mem[a1], mem[a0]};
        endcase
    end

    always @(posedge CLK) begin
        if (mem_WE) begin
            mem[a0] <= mem_WD[7:0];
            if (mem_funct3 != 3'b000) mem[a1] <= mem_WD[15:8];
            if (mem_funct3 == 3'b010) begin
                mem[a2] <= mem_WD[23:16];
                mem[a3] <= mem_WD[31:24];
            end
        end
    end

    always @(negedge CLK) begin
        if (mem_WE) we_cnt++;
        check("gnt_onehot", {31'h0, c_gnt & h_gnt}, 32'h0);
        check("done_onehot", {31'h0, c_done & h_done}, 32'h0);
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic put_word(input logic [7:0] a, input logic [31:0] w);
        mem[a]        = w[7:0];
        mem[a + 8'd1] = w[15:8];
        mem[a + 8'd2] = w[23:16];
        mem[a + 8'd3] = w[31:24];
    endtask

    // One complete access with cycle-exact checks of gnt, WE, done, rdata and err.
    task automatic xfer(input string tag, input logic host, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input logic exp_we,
                        input logic [31:0] exp_rdata, input logic exp_err);
        logic gnt;
        if (host) begin
            h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wdata; h_funct3 = f3;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_funct3 = f3;
        end
        #1;
        gnt = host ? h_gnt : c_gnt;
        check({tag, " gnt"}, {31'h0, gnt}, 32'h1);
        check({tag, " we_in_gnt"}, {31'h0, mem_WE}, 32'h0);
        cyc();
        c_req = 1'b0;
        h_req = 1'b0;
        check({tag, " we_access"}, {31'h0, mem_WE}, {31'h0, exp_we});
        check({tag, " addr"}, mem_A, addr);
        check({tag, " early_done"}, {30'h0, c_done, h_done}, 32'h0);
        cyc();
        check({tag, " done"}, {30'h0, c_done, h_done}, host ? 32'h1 : 32'h2);
        check({tag, " rdata"}, host ? h_rdata : c_rdata, exp_rdata);
        check({tag, " err"}, {31'h0, host ? h_err : c_err}, {31'h0, exp_err});
        check({tag, " we_resp"}, {31'h0, mem_WE}, 32'h0);
        cyc();
        check({tag, " done_gone"}, {30'h0, c_done, h_done}, 32'h0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;
    endtask

    int w0;
    logic exp_c, exp_h;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        put_word(8'h10, 32'hDEAD_BEEF);
        put_word(8'h30, 32'h0000_0080);
        put_word(8'h40, 32'h0000_8001);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_funct3 = 3'b010;
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h0; h_wdata = 32'h0; h_funct3 = 3'b010;
        p_c_req = 1'b0; p_h_req = 1'b0;
        RST = 1'b1;
        cyc();
        #1;
        check("rst gnt_forced", {30'h0, c_gnt, h_gnt}, 32'h0);
        check("rst we_forced", {31'h0, mem_WE}, 32'h0);
        c_req = 1'b0; h_req = 1'b0;
        cyc();
        RST = 1'b0;
        check("rst c_rdata", c_rdata, 32'h0);
        check("rst mem_A", mem_A, 32'h0);
        check("rst done", {30'h0, c_done, h_done}, 32'h0);

        w0 = we_cnt;
        xfer("core_lw", 1'b0, 1'b0, 32'h8000_0010, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF, 1'b0);
        check("core_lw we_count", we_cnt - w0, 0);

        w0 = we_cnt;
        xfer("host_sw", 1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678, 3'b010, 1'b1, 32'h0, 1'b0);
        check("host_sw we_count", we_cnt - w0, 1);
        xfer("core_lbu", 1'b0, 1'b0, 32'h8000_0004, 32'h0, 3'b100, 1'b0, 32'h0000_0078, 1'b0);

        w0 = we_cnt;
        xfer("core_bad_st", 1'b0, 1'b1, 32'h8000_0020, 32'hAAAA_AAAA, 3'b011, 1'b0, 32'h0000_0078, 1'b1);
        check("core_bad_st we_count", we_cnt - w0, 0);
        check("core_bad_st mem", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h0);

        xfer("core_lb", 1'b0, 1'b0, 32'h0000_0030, 32'h0, 3'b000, 1'b0, 32'hFFFF_FF80, 1'b0);
        xfer("core_lh", 1'b0, 1'b0, 32'h0000_0040, 32'h0, 3'b001, 1'b0, 32'hFFFF_8001, 1'b0);
        xfer("core_bad_ld", 1'b0, 1'b0, 32'h0000_0040, 32'h0, 3'b110, 1'b0, 32'hFFFF_8001, 1'b1);
        xfer("host_bad_st", 1'b1, 1'b1, 32'h0000_0060, 32'h5555_5555, 3'b100, 1'b0, 32'h0, 1'b1);
        check("host_bad_st mem", {mem[8'h63], mem[8'h62], mem[8'h61], mem[8'h60]}, 32'h0);

        // Continuous contention on both arbiters from a fresh reset.
        do_reset();
        c_we = 1'b0; c_addr = 32'h10; c_funct3 = 3'b010;
        h_we = 1'b0; h_addr = 32'h10; h_funct3 = 3'b010;
        c_req = 1'b1; h_req = 1'b1; p_c_req = 1'b1; p_h_req = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            exp_c = (i % 3 == 0) && ((i / 3) % 2 == 0);
            exp_h = (i % 3 == 0) && ((i / 3) % 2 == 1);
            check($sformatf("rr gnt c%0d", i), {31'h0, c_gnt}, {31'h0, exp_c});
            check($sformatf("rr gnt h%0d", i), {31'h0, h_gnt}, {31'h0, exp_h});
            check($sformatf("prio gnt c%0d", i), {31'h0, p_c_gnt}, 32'h0);
            check($sformatf("prio gnt h%0d", i), {31'h0, p_h_gnt}, {31'h0, (i % 3 == 0)});
            if (i == 11) begin
                c_req = 1'b0; h_req = 1'b0; p_c_req = 1'b0; p_h_req = 1'b0;
            end
            cyc();
            #1;
        end

        // Reset in the middle of a host store abandons it.
        put_word(8'h50, 32'h0);
        w0 = we_cnt;
        h_req = 1'b1; h_we = 1'b1; h_addr = 32'h50; h_wdata = 32'hCAFE_F00D; h_funct3 = 3'b010;
        #1;
        check("rst_mid gnt", {31'h0, h_gnt}, 32'h1);
        cyc();
        h_req = 1'b0;
        RST = 1'b1;
        #1;
        check("rst_mid we_forced", {31'h0, mem_WE}, 32'h0);
        cyc();
        RST = 1'b0;
        check("rst_mid outs", {c_gnt, h_gnt, c_done, h_done, mem_WE, c_err, h_err}, 32'h0);
        check("rst_mid mem_A", mem_A, 32'h0);
        check("rst_mid mem_WD", mem_WD, 32'h0);
        check("rst_mid rdata", c_rdata | h_rdata, 32'h0);
        check("rst_mid we_count", we_cnt - w0, 0);
        check("rst_mid mem", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_funct3 = 3'b010;
        #1;
        check("rst_mid idle_gnt", {31'h0, c_gnt}, 32'h1);
        check("rst_mid no_h_done", {31'h0, h_done}, 32'h0);
        cyc();
        c_req = 1'b0;
        cyc();
        check("rst_mid after core done", {30'h0, c_done, h_done}, 32'h2);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
